// File: rtl/uart_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_n_pkg
//  Description : Shared types and constants for the multi-byte UART receiver:
//                state encoding, message geometry and the num -> N clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_n_pkg;

    localparam int MAX_BYTES = 8;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4,
        ST_BREAK = 3'd5
    } state_e;

    // Requested byte count to effective count: 0 stays 0 (ignored), >8 clamps to 8
    function automatic logic [3:0] clamp_num(input logic [3:0] num);
        if (num > 4'(MAX_BYTES)) begin
            return 4'(MAX_BYTES);
        end
        return num;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_n_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_n_rx_if
//  Description : Serial-line and message-report bundle of the multi-byte UART
//                receiver. The receiver uses the slave view, the consumer
//                (command decoder / line driver) the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_n_rx_if;
    import uart_n_pkg::*;

    logic                        i_rx;
    logic [3:0]                  i_num;
    logic [MAX_BYTES*BYTE_W-1:0] o_buffer;
    logic [3:0]                  o_count;
    logic                        o_valid;
    logic                        o_frame_err;
    logic                        o_busy;

    modport slave (
        input  i_rx,
        input  i_num,
        output o_buffer,
        output o_count,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport master (
        output i_rx,
        output i_num,
        input  o_buffer,
        input  o_count,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : Single 8N1 byte engine. Synchronises RX, detects a falling
//                edge, confirms the start bit at mid-bit (glitch rejection),
//                shifts in 8 data bits LSB first and checks the stop bit.
//                Start confirmation, byte completion and stop errors are
//                reported as combinational pulses on the sampling cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_n_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx,
    input  logic              i_enable,
    output logic              o_rx_s,
    output logic              o_start_ok,
    output logic              o_byte_valid,
    output logic [BYTE_W-1:0] o_byte_data,
    output logic              o_stop_err
);

    localparam int                 C_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [C_CNT_W-1:0] C_HALF_M1 = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_M1 = C_CNT_W'(CLKS_PER_BIT - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bit;
    logic [BYTE_W-1:0]   r_shift;
    logic                w_fall;
    logic                w_half;
    logic                w_full;

    assign w_fall       = r_prev & ~r_sync2;
    assign w_half       = (r_cnt == C_HALF_M1);
    assign w_full       = (r_cnt == C_FULL_M1);
    assign o_rx_s       = r_sync2;
    assign o_byte_data  = r_shift;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Bit-engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-sample event pulses
    always_comb begin
        w_state_nxt  = r_state;
        o_start_ok   = 1'b0;
        o_byte_valid = 1'b0;
        o_stop_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && w_fall) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_half) begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_DATA;
                        o_start_ok  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_full && (r_bit == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_full) begin
                    w_state_nxt  = ST_IDLE;
                    o_byte_valid = r_sync2;
                    o_stop_err   = ~r_sync2;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit-period counter, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= 3'd0;
                end
                ST_START: begin
                    r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                end
                ST_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {r_sync2, r_shift[BYTE_W-1:1]};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_n_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_n_rx
//  Description : Multi-byte UART receiver. Gathers up to 8 consecutive 8N1
//                frames into a 64-bit buffer (byte k in [8k+7:8k]) and pulses
//                valid once per complete message. A bad stop bit aborts the
//                message and parks the block until the line returns high.
//                Optional macro UART_N_RX_TIMEOUT_EN: flush a partial message
//                after TIMEOUT_BITS idle bit-times between bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_n_rx
    import uart_n_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_n_rx_if.slave rx_bus
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_n_rx: CLKS_PER_BIT must be at least 4");
    end
    if (TIMEOUT_BITS < 1) begin : g_bad_timeout_bits
        $error("uart_n_rx: TIMEOUT_BITS must be at least 1");
    end

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [3:0]                  r_n;
    logic [3:0]                  r_count;
    logic [MAX_BYTES*BYTE_W-1:0] r_buffer;
    logic                        r_valid;
    logic                        r_ferr;
    logic                        r_busy;

    logic                        w_rx_s;
    logic                        w_start_ok;
    logic                        w_byte_valid;
    logic                        w_stop_err;
    logic [BYTE_W-1:0]           w_byte_data;
    logic [3:0]                  w_n_new;
    logic                        w_msg_start;
    logic                        w_last;
    logic                        w_tmo_done;

    assign w_n_new     = clamp_num(rx_bus.i_num);
    assign w_msg_start = (r_state == ST_IDLE) && w_start_ok && (w_n_new != 4'd0);
    assign w_last      = ((r_count + 4'd1) == r_n);

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (rx_bus.i_rx),
        .i_enable     (r_state != ST_BREAK),
        .o_rx_s       (w_rx_s),
        .o_start_ok   (w_start_ok),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_stop_err   (w_stop_err)
    );

`ifdef UART_N_RX_TIMEOUT_EN
    localparam int               C_TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               C_TMO_W      = $clog2(C_TMO_CYCLES);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(C_TMO_CYCLES - 1);

    logic [C_TMO_W-1:0] r_tmo;
    logic               r_rx_prev;
    logic               w_fall;

    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_tmo_done = (r_state == ST_GAP) && (r_tmo == C_TMO_LAST);

    // Inter-byte idle timer: runs only in GAP, restarts on any falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo     <= '0;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
            if ((r_state != ST_GAP) || w_fall) begin
                r_tmo <= '0;
            end else if (!w_tmo_done) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end
`else
    assign w_tmo_done = 1'b0;
`endif

    // Message state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Message sequencing: DATA covers a byte in flight in the bit engine
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_msg_start) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_GAP: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_DATA;
                end else if (w_tmo_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_byte_valid) begin
                    w_state_nxt = w_last ? ST_IDLE : ST_GAP;
                end else if (w_stop_err) begin
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Buffer lanes, byte count, latched N and the status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buffer <= '0;
            r_count  <= 4'd0;
            r_n      <= 4'd0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_msg_start) begin
                        r_buffer <= '0;
                        r_count  <= 4'd0;
                        r_n      <= w_n_new;
                        r_busy   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_byte_valid) begin
                        r_buffer[r_count[2:0]*BYTE_W +: BYTE_W] <= w_byte_data;
                        r_count <= r_count + 4'd1;
                        if (w_last) begin
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_stop_err) begin
                        r_ferr <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_tmo_done && !w_start_ok) begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_bus.o_buffer    = r_buffer;
    assign rx_bus.o_count     = r_count;
    assign rx_bus.o_valid     = r_valid;
    assign rx_bus.o_frame_err = r_ferr;
    assign rx_bus.o_busy      = r_busy;

endmodule
`default_nettype wire
